// File: rtl/hms_pkg.sv
// hms_pkg: shared mode/position encodings, field widths and limits for the
// hms_time_core timekeeping block.
package hms_pkg;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int MAX_59 = 59;

  // Next setup position: advance on request; the unused code 3 falls back to SEC.
  function automatic pos_e pos_next(input pos_e cur, input logic adv);
    pos_e nxt;
    case (cur)
      POS_SEC:  nxt = adv ? POS_MIN  : POS_SEC;
      POS_MIN:  nxt = adv ? POS_HOUR : POS_MIN;
      POS_HOUR: nxt = adv ? POS_SEC  : POS_HOUR;
      default:  nxt = POS_SEC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hms_time_core_mod_cnt.sv
// mod_cnt: modulo-(MAX+1) counter. i_en is the chained carry from the lower
// field and produces o_wrap on wrap; i_inc is a setup increment that wraps
// silently without generating a carry.
module mod_cnt
  import hms_pkg::*;
#(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_inc,
  output logic [W-1:0] o_val,
  output logic         o_wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] val_r;
  logic [W-1:0] val_nxt_s;
  logic         at_max_s;

  // Next value: step on carry or setup increment; anything at/above MAX wraps to 0
  always_comb begin
    at_max_s  = (val_r >= MAX_V);
    val_nxt_s = val_r;
    if (i_en || i_inc) begin
      if (at_max_s) begin
        val_nxt_s = {W{1'b0}};
      end else begin
        val_nxt_s = val_r + ONE_V;
      end
    end else begin
      val_nxt_s = val_r;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_r <= {W{1'b0}};
    end else begin
      val_r <= val_nxt_s;
    end
  end

  assign o_val  = val_r;
  assign o_wrap = i_en & at_max_s;

endmodule

// File: rtl/hms_time_core.sv
// hms_time_core: single-clock hh:mm:ss timekeeper with setup mode, blink
// strobe and day pulse. Optional alarm is built when HMS_ALARM_EN is defined.
module hms_time_core
  import hms_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1,
  parameter int HOUR_MAX  = 23,
  parameter int BLINK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef HMS_ALARM_EN
  input  logic [HOUR_W-1:0] i_alarm_hour,
  input  logic [MIN_W-1:0]  i_alarm_min,
  input  logic              i_alarm_arm,
  input  logic              i_alarm_ack_pls,
  output logic              o_alarm,
`endif
  input  logic              i_mode_pls,
  input  logic              i_pos_pls,
  input  logic              i_inc_pls,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_mode,
  output logic [1:0]        o_pos,
  output logic              o_tick,
  output logic              o_blink,
  output logic              o_day_pls
);

  localparam int PERIOD = (CLK_HZ / TICK_HZ > 1) ? (CLK_HZ / TICK_HZ) : 1;
  localparam int PRE_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HALF   = (PERIOD / BLINK_DIV > 1) ? (PERIOD / BLINK_DIV) : 1;
  localparam int BLK_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(PERIOD - 1);
  localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(HALF - 1);

  mode_e             mode_r, mode_nxt_s;
  pos_e              pos_r;
  logic [PRE_W-1:0]  pre_r, pre_nxt_s;
  logic [BLK_W-1:0]  blink_cnt_r;
  logic              blink_r, tick_r, day_r;
  logic              tick_s, setup_s;
  logic              sec_inc_s, min_inc_s, hour_inc_s;
  logic              sec_wrap_s, min_wrap_s, hour_wrap_s;
  logic [SEC_W-1:0]  sec_q_s;
  logic [MIN_W-1:0]  min_q_s;
  logic [HOUR_W-1:0] hour_q_s;

  // Mode FSM next state: a mode pulse toggles CLOCK/SETUP
  always_comb begin
    mode_nxt_s = mode_r;
    if (i_mode_pls) begin
      case (mode_r)
        MODE_CLOCK: mode_nxt_s = MODE_SETUP;
        MODE_SETUP: mode_nxt_s = MODE_CLOCK;
        default:    mode_nxt_s = MODE_CLOCK;
      endcase
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Prescaler, tick and setup-increment steering (increment uses pre-toggle mode and pre-advance pos)
  always_comb begin
    setup_s    = (mode_r == MODE_SETUP);
    tick_s     = (mode_r == MODE_CLOCK) && (pre_r == PRE_TC);
    pre_nxt_s  = {PRE_W{1'b0}};
    if ((mode_r == MODE_CLOCK) && (mode_nxt_s == MODE_CLOCK)) begin
      if (tick_s) begin
        pre_nxt_s = {PRE_W{1'b0}};
      end else begin
        pre_nxt_s = pre_r + PRE_W'(1);
      end
    end else begin
      pre_nxt_s = {PRE_W{1'b0}};
    end
    sec_inc_s  = setup_s && i_inc_pls && (pos_r == POS_SEC);
    min_inc_s  = setup_s && i_inc_pls && (pos_r == POS_MIN);
    hour_inc_s = setup_s && i_inc_pls && (pos_r == POS_HOUR);
  end

  // Control state and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_CLOCK;
      pos_r  <= POS_SEC;
      pre_r  <= {PRE_W{1'b0}};
      tick_r <= 1'b0;
      day_r  <= 1'b0;
    end else begin
      mode_r <= mode_nxt_s;
      pos_r  <= pos_next(pos_r, i_pos_pls);
      pre_r  <= pre_nxt_s;
      tick_r <= tick_s;
      day_r  <= hour_wrap_s;
    end
  end

  // Blink divider: held high in CLOCK, free-running half-periods in SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_r     <= 1'b0;
      blink_cnt_r <= {BLK_W{1'b0}};
    end else if (mode_r == MODE_CLOCK) begin
      blink_r     <= 1'b1;
      blink_cnt_r <= {BLK_W{1'b0}};
    end else if (blink_cnt_r == BLK_TC) begin
      blink_r     <= ~blink_r;
      blink_cnt_r <= {BLK_W{1'b0}};
    end else begin
      blink_cnt_r <= blink_cnt_r + BLK_W'(1);
    end
  end

  mod_cnt #(.W(SEC_W), .MAX(MAX_59)) u_sec (
    .clk(clk), .rst_n(rst_n), .i_en(tick_s), .i_inc(sec_inc_s),
    .o_val(sec_q_s), .o_wrap(sec_wrap_s)
  );

  mod_cnt #(.W(MIN_W), .MAX(MAX_59)) u_min (
    .clk(clk), .rst_n(rst_n), .i_en(sec_wrap_s), .i_inc(min_inc_s),
    .o_val(min_q_s), .o_wrap(min_wrap_s)
  );

  mod_cnt #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst_n(rst_n), .i_en(min_wrap_s), .i_inc(hour_inc_s),
    .o_val(hour_q_s), .o_wrap(hour_wrap_s)
  );

`ifdef HMS_ALARM_EN
  logic [MIN_W-1:0]  min_after_s;
  logic [HOUR_W-1:0] hour_after_s;
  logic              alarm_hit_s;
  logic              alarm_r;
  logic [5:0]        alarm_cnt_r;

  // Time shown after this cycle's carry chain; hit only on a tick that lands on sec 0
  always_comb begin
    if (min_wrap_s) begin
      min_after_s = {MIN_W{1'b0}};
    end else if (sec_wrap_s) begin
      min_after_s = min_q_s + MIN_W'(1);
    end else begin
      min_after_s = min_q_s;
    end
    if (hour_wrap_s) begin
      hour_after_s = {HOUR_W{1'b0}};
    end else if (min_wrap_s) begin
      hour_after_s = hour_q_s + HOUR_W'(1);
    end else begin
      hour_after_s = hour_q_s;
    end
    alarm_hit_s = i_alarm_arm && sec_wrap_s &&
                  (min_after_s == i_alarm_min) && (hour_after_s == i_alarm_hour);
  end

  // Alarm latch: ack or disarm clear first, then set on hit, else self-clear after 60 ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_r     <= 1'b0;
      alarm_cnt_r <= 6'd0;
    end else if (!i_alarm_arm || i_alarm_ack_pls) begin
      alarm_r     <= 1'b0;
      alarm_cnt_r <= 6'd0;
    end else if (alarm_hit_s) begin
      alarm_r     <= 1'b1;
      alarm_cnt_r <= 6'd0;
    end else if (alarm_r && tick_s) begin
      if (alarm_cnt_r == 6'd59) begin
        alarm_r     <= 1'b0;
        alarm_cnt_r <= 6'd0;
      end else begin
        alarm_cnt_r <= alarm_cnt_r + 6'd1;
      end
    end
  end

  assign o_alarm = alarm_r;
`endif

  assign o_sec     = sec_q_s;
  assign o_min     = min_q_s;
  assign o_hour    = hour_q_s;
  assign o_mode    = mode_r;
  assign o_pos     = pos_r;
  assign o_tick    = tick_r;
  assign o_blink   = blink_r;
  assign o_day_pls = day_r;

endmodule

// File: tb/tb_hms_time_core.sv
// tb_hms_time_core: drives a 24-hour and a 12-hour (HOUR_MAX=11) instance with
// the same pulses and checks both against a seconds-of-day reference model.
module tb_hms_time_core;

  localparam int P = 20;   // clock cycles per second tick
  localparam int H = 10;   // blink half-period in cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mp = 1'b0, pp = 1'b0, ip = 1'b0, ack = 1'b0, arm = 1'b0;
  logic [4:0] ah = 5'd0;
  logic [5:0] am = 6'd0;

  logic [5:0] sec0, min0, sec1, min1;
  logic [4:0] hour0, hour1;
  logic [1:0] pos0, pos1;
  logic mode0, mode1, tick0, tick1, blink0, blink1, day0, day1;
`ifdef HMS_ALARM_EN
  logic alarm0, alarm1;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model: time as seconds of day per instance
  int m_mode, m_pos, m_phase, m_k, m_alarm, m_acnt;
  int m_secs [2];
  bit e_tick, e_blink;
  bit e_day [2];

  always #5 clk = ~clk;

  hms_time_core #(.CLK_HZ(20), .TICK_HZ(1), .HOUR_MAX(23), .BLINK_DIV(2)) dut24 (
    .clk(clk), .rst_n(rst_n),
`ifdef HMS_ALARM_EN
    .i_alarm_hour(ah), .i_alarm_min(am), .i_alarm_arm(arm), .i_alarm_ack_pls(ack), .o_alarm(alarm0),
`endif
    .i_mode_pls(mp), .i_pos_pls(pp), .i_inc_pls(ip),
    .o_sec(sec0), .o_min(min0), .o_hour(hour0), .o_mode(mode0), .o_pos(pos0),
    .o_tick(tick0), .o_blink(blink0), .o_day_pls(day0)
  );

  hms_time_core #(.CLK_HZ(20), .TICK_HZ(1), .HOUR_MAX(11), .BLINK_DIV(2)) dut12 (
    .clk(clk), .rst_n(rst_n),
`ifdef HMS_ALARM_EN
    .i_alarm_hour(ah), .i_alarm_min(am), .i_alarm_arm(1'b0), .i_alarm_ack_pls(ack), .o_alarm(alarm1),
`endif
    .i_mode_pls(mp), .i_pos_pls(pp), .i_inc_pls(ip),
    .o_sec(sec1), .o_min(min1), .o_hour(hour1), .o_mode(mode1), .o_pos(pos1),
    .o_tick(tick1), .o_blink(blink1), .o_day_pls(day1)
  );

  function automatic int day_len(input int i);
    return (i == 0) ? 86400 : 43200;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_phase = 0; m_k = 0; m_alarm = 0; m_acnt = 0;
    m_secs[0] = 0; m_secs[1] = 0;
    e_tick = 1'b0; e_blink = 1'b0; e_day[0] = 1'b0; e_day[1] = 1'b0;
  endtask

  // one clock edge of the specified behaviour, using the inputs applied to it
  task automatic model_step(input bit mpv, input bit ppv, input bit ipv, input bit ackv);
    bit tk;
    int h, mi, s;
    tk = (m_mode == 0) && (m_phase == P - 1);
    for (int i = 0; i < 2; i++) begin
      e_day[i] = 1'b0;
      if (tk) begin
        e_day[i]  = (m_secs[i] == day_len(i) - 1);
        m_secs[i] = (m_secs[i] + 1) % day_len(i);
      end
      if (m_mode == 1 && ipv) begin
        h = m_secs[i] / 3600; mi = (m_secs[i] / 60) % 60; s = m_secs[i] % 60;
        case (m_pos)
          0:       s  = (s + 1) % 60;
          1:       mi = (mi + 1) % 60;
          default: h  = (h + 1) % (day_len(i) / 3600);
        endcase
        m_secs[i] = h * 3600 + mi * 60 + s;
      end
    end
    if (!arm || ackv) begin
      m_alarm = 0;
    end else if (tk && (m_secs[0] % 60 == 0) && (m_secs[0] / 3600 == int'(ah)) &&
                 ((m_secs[0] / 60) % 60 == int'(am))) begin
      m_alarm = 1; m_acnt = 0;
    end else if (m_alarm == 1 && tk) begin
      m_acnt++;
      if (m_acnt == 60) m_alarm = 0;
    end
    if (m_mode == 0) begin
      m_k = 0; e_blink = 1'b1;
    end else begin
      m_k++; e_blink = ((m_k / H) % 2 == 0);
    end
    if (m_mode == 0 && !mpv) m_phase = (m_phase + 1) % P;
    else m_phase = 0;
    if (mpv) m_mode = 1 - m_mode;
    if (ppv) m_pos = (m_pos + 1) % 3;
    e_tick = tk;
  endtask

  // apply pulses for one cycle (called at a falling edge), advance the model
  task automatic drive_cycle(input bit mpv, input bit ppv, input bit ipv, input bit ackv);
    mp = mpv; pp = ppv; ip = ipv; ack = ackv;
    @(posedge clk);
    model_step(mpv, ppv, ipv, ackv);
    @(negedge clk);
    mp = 1'b0; pp = 1'b0; ip = 1'b0; ack = 1'b0;
  endtask

  task automatic ensure_mode(input int m);
    if (m_mode != m) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goto_pos(input int p);
    for (int n = 0; n < 3 && m_pos != p; n++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // preload a 24-hour time by setup increments (must be in SETUP)
  task automatic set_time(input int h, input int mi, input int s);
    int c;
    goto_pos(0);
    c = (s - m_secs[0] % 60 + 60) % 60;
    repeat (c) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    goto_pos(1);
    c = (mi - (m_secs[0] / 60) % 60 + 60) % 60;
    repeat (c) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    goto_pos(2);
    c = (h - m_secs[0] / 3600 + 24) % 24;
    repeat (c) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({sec0, min0, hour0, mode0, pos0, tick0, blink0, day0} !== 23'd0) begin
      n_err++;
      $display("FAIL reset24: got %h want 0", {sec0, min0, hour0, mode0, pos0, tick0, blink0, day0});
    end
    n_vec++;
    if ({sec1, min1, hour1, mode1, pos1, tick1, blink1, day1} !== 23'd0) begin
      n_err++;
      $display("FAIL reset12: got %h want 0", {sec1, min1, hour1, mode1, pos1, tick1, blink1, day1});
    end
`ifdef HMS_ALARM_EN
    n_vec++;
    if (alarm0 !== 1'b0) begin n_err++; $display("FAIL reset_alarm: got %b want 0", alarm0); end
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_tick();
    int ticks = 0, days = 0;
    repeat (P) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (tick0) ticks++;
      if (day0) days++;
    end
    n_vec++;
    if (sec0 !== 6'd1 || sec1 !== 6'd1) begin
      n_err++; $display("FAIL first_sec: got %0d/%0d want 1", sec0, sec1);
    end
    n_vec++;
    if (ticks != 1 || days != 0) begin
      n_err++; $display("FAIL first_tick: got ticks=%0d days=%0d want 1/0", ticks, days);
    end
    n_vec++;
    if (blink0 !== 1'b1) begin n_err++; $display("FAIL clock_blink: got %b want 1", blink0); end
  endtask

  task automatic test_rollover();
    int ticks = 0;
    ensure_mode(1);
    set_time(23, 59, 58);
    ensure_mode(0);
    for (int c = 0; c < 3 * P && ticks < 2; c++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (tick0) begin
        ticks++;
        if (ticks == 1) begin
          n_vec++;
          if ({hour0, min0, sec0, day0} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
            n_err++; $display("FAIL roll_first: got %0d:%0d:%0d day=%b want 23:59:59 day=0", hour0, min0, sec0, day0);
          end
        end else begin
          n_vec++;
          if ({hour0, min0, sec0, day0, tick0} !== {5'd0, 6'd0, 6'd0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL roll24: got %0d:%0d:%0d day=%b want 0:0:0 day=1", hour0, min0, sec0, day0);
          end
          n_vec++;
          if ({hour1, min1, sec1, day1, tick1} !== {5'd0, 6'd0, 6'd0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL roll12: got %0d:%0d:%0d day=%b want 0:0:0 day=1", hour1, min1, sec1, day1);
          end
        end
      end
    end
    n_vec++;
    if (ticks != 2) begin n_err++; $display("FAIL roll_timeout: got %0d ticks want 2", ticks); end
  endtask

  task automatic test_setup_inc();
    logic [5:0] mb, sb;
    logic [4:0] hb;
    ensure_mode(1);
    set_time(m_secs[0] / 3600, (m_secs[0] / 60) % 60, 59);
    goto_pos(0);
    mb = min0; hb = hour0;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({sec0, min0, hour0, day0} !== {6'd0, mb, hb, 1'b0}) begin
      n_err++; $display("FAIL setup_sec_wrap: got %0d:%0d:%0d want %0d:%0d:0", hour0, min0, sec0, hb, mb);
    end
    ensure_mode(0);
    sb = sec0; mb = min0; hb = hour0;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({sec0, min0, hour0} !== {sb, mb, hb}) begin
      n_err++; $display("FAIL clock_inc_ignored: got %0d:%0d:%0d want %0d:%0d:%0d", hour0, min0, sec0, hb, mb, sb);
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({mode0, sec0, min0, hour0} !== {1'b1, sb, mb, hb}) begin
      n_err++; $display("FAIL mode_inc_same: got mode=%b sec=%0d want mode=1 sec=%0d", mode0, sec0, sb);
    end
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({pos0, sec0} !== {2'd1, 6'((int'(sb) + 1) % 60)}) begin
      n_err++; $display("FAIL pos_inc_same: got pos=%0d sec=%0d want pos=1 sec=%0d", pos0, sec0, (int'(sb) + 1) % 60);
    end
    ensure_mode(0);
  endtask

  task automatic test_freeze();
    logic [16:0] tb;
    logic pb;
    int ticks = 0, tog = 0, c = 0;
    bit found = 0;
    for (int n = 0; n < 2 * P && !found; n++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      found = tick0;
    end
    repeat (7) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tb = {hour0, min0, sec0}; pb = blink0;
    repeat (100) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (tick0) ticks++;
      if (blink0 !== pb) tog++;
      pb = blink0;
    end
    n_vec++;
    if (ticks != 0 || {hour0, min0, sec0} !== tb) begin
      n_err++; $display("FAIL freeze: got ticks=%0d time=%h want 0 / %h", ticks, {hour0, min0, sec0}, tb);
    end
    n_vec++;
    if (tog != 100 / H) begin n_err++; $display("FAIL blink_toggles: got %0d want %0d", tog, 100 / H); end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    found = 0;
    while (c < 2 * P && !found) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      c++;
      found = tick0;
    end
    n_vec++;
    if (!found || c != P) begin n_err++; $display("FAIL restart_tick: got %0d cycles (found=%0d) want %0d", c, found, P); end
  endtask

`ifdef HMS_ALARM_EN
  task automatic test_alarm();
    int ticks = 0;
    bit found;
    ah = 5'd0; am = 6'd1; arm = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      ensure_mode(1);
      set_time(0, 0, 59);
      ensure_mode(0);
      found = 0;
      for (int n = 0; n < 2 * P && !found; n++) begin
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        found = tick0;
      end
      n_vec++;
      if (!found || alarm0 !== 1'b1 || {hour0, min0, sec0} !== {5'd0, 6'd1, 6'd0}) begin
        n_err++; $display("FAIL alarm_set%0d: got alarm=%b time=%0d:%0d:%0d want 1 at 0:1:0", pass, alarm0, hour0, min0, sec0);
      end
      if (pass == 0) begin
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (alarm0 !== 1'b0) begin n_err++; $display("FAIL alarm_ack: got %b want 0", alarm0); end
      end else begin
        ticks = 0;
        for (int n = 0; n < 70 * P && alarm0 === 1'b1; n++) begin
          drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
          if (tick0) ticks++;
        end
        n_vec++;
        if (ticks != 60 || alarm0 !== 1'b0) begin
          n_err++; $display("FAIL alarm_timeout: got %0d ticks alarm=%b want 60 / 0", ticks, alarm0);
        end
      end
    end
    arm = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random(input int cycles);
    logic [22:0] exp_v;
    for (int c = 0; c < cycles; c++) begin
      drive_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 3) == 0), 1'b0);
      for (int i = 0; i < 2; i++) begin
        exp_v = {6'(m_secs[i] % 60), 6'((m_secs[i] / 60) % 60), 5'(m_secs[i] / 3600),
                 1'(m_mode), 2'(m_pos), e_tick, e_blink, e_day[i]};
        n_vec++;
        if (i == 0 && {sec0, min0, hour0, mode0, pos0, tick0, blink0, day0} !== exp_v) begin
          n_err++; $display("FAIL rand24 cycle %0d: got %h want %h", c, {sec0, min0, hour0, mode0, pos0, tick0, blink0, day0}, exp_v);
        end
        if (i == 1 && {sec1, min1, hour1, mode1, pos1, tick1, blink1, day1} !== exp_v) begin
          n_err++; $display("FAIL rand12 cycle %0d: got %h want %h", c, {sec1, min1, hour1, mode1, pos1, tick1, blink1, day1}, exp_v);
        end
      end
`ifdef HMS_ALARM_EN
      n_vec++;
      if (alarm0 !== 1'(m_alarm)) begin n_err++; $display("FAIL rand_alarm cycle %0d: got %b want %0d", c, alarm0, m_alarm); end
`endif
    end
  endtask

  task automatic test_mid_reset();
    #2;
    mp = 1'b1; ip = 1'b1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({sec0, min0, hour0, mode0, pos0, tick0, blink0, day0} !== 23'd0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", {sec0, min0, hour0, mode0, pos0, tick0, blink0, day0});
    end
    @(posedge clk);
    @(negedge clk);
    mp = 1'b0; ip = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_rollover();
    test_setup_inc();
    test_freeze();
`ifdef HMS_ALARM_EN
    test_alarm();
`endif
    test_random(3000);
    test_mid_reset();
    test_random(500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hms_time_core.md
Name: hms_time_core

Overview:
- Synchronous, single-clock timekeeping core: seconds, minutes and hours counters with a user setup mode.
- Replaces the older design, which clocked counters from divided clocks; every register here runs on clk and advances on one-cycle enables.
- Sits between the button debouncers (upstream) and the digit splitter / multiplexed 7-segment display driver (downstream).
- Adds an hours field, 12/24-hour wrap, a blink strobe for the field being set, and an optional alarm.

Parameters:
- CLK_HZ, 50000000: input clock frequency in Hz.
- TICK_HZ, 1: rate at which seconds advance. Benches shrink CLK_HZ/TICK_HZ to speed simulation.
- HOUR_MAX, 23: last hour value before wrap to 0. Legal values are 23 or 11.
- BLINK_DIV, 2: o_blink toggles every TICK_HZ/BLINK_DIV... simplified: o_blink toggles once every (CLK_HZ/TICK_HZ)/BLINK_DIV cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_mode_pls  in  1  one-cycle pulse (already debounced) that toggles between CLOCK and SETUP
- i_pos_pls  in  1  one-cycle pulse that advances the selected setup field
- i_inc_pls  in  1  one-cycle pulse that increments the selected field (SETUP only)
- o_sec  out  6  seconds, 0..59
- o_min  out  6  minutes, 0..59
- o_hour  out  5  hours, 0..HOUR_MAX
- o_mode  out  1  0 = CLOCK, 1 = SETUP
- o_pos  out  2  0 = SEC, 1 = MIN, 2 = HOUR
- o_tick  out  1  one-cycle pulse each time the seconds counter advances in CLOCK mode
- o_blink  out  1  square wave the display uses to flash the selected field in SETUP
- o_day_pls  out  1  one-cycle pulse on the hour wrap HOUR_MAX -> 0

Behaviour:
- Reset: all outputs and internal registers go to 0, which gives mode CLOCK, pos SEC, time 00:00:00, and the prescaler cleared.
- Prescaler:
  - Counts 0..(CLK_HZ/TICK_HZ)-1 in CLOCK mode only.
  - At terminal count it wraps to 0 and issues the internal tick.
  - o_tick is registered and rises 1 cycle after terminal count.
- CLOCK mode carry chain, evaluated in the same cycle as the tick:
  - sec increments on each tick.
  - At 59 the tick wraps sec to 0 and increments min in that same cycle.
  - min 59 -> 0 increments hour.
  - hour HOUR_MAX -> 0 pulses o_day_pls for 1 cycle, aligned with o_tick.
  - Counter outputs update 1 cycle after the prescaler terminal count.
- Mode FSM, states CLOCK and SETUP:
  - i_mode_pls toggles the state; it takes effect on the next cycle.
  - CLOCK -> SETUP: freeze the prescaler at 0; no ticks while in SETUP.
  - SETUP -> CLOCK: restart the prescaler from 0, so the first tick arrives a full period later; o_pos is unchanged.
- Position: i_pos_pls cycles SEC -> MIN -> HOUR -> SEC in either mode. Encoding 3 is unreachable; if reached it recovers to SEC.
- Increment in SETUP: i_inc_pls increments the selected field by 1.
  - The field wraps at its own maximum (59, 59, HOUR_MAX).
  - No carry into the next field, and no o_day_pls.
  - i_inc_pls is ignored in CLOCK mode.
- Simultaneous pulses in the same cycle:
  - i_mode_pls with i_inc_pls: the increment uses the pre-toggle mode.
  - i_pos_pls with i_inc_pls: the increment uses the pre-advance position.
- o_blink:
  - Free-running divider of period (CLK_HZ/TICK_HZ)/BLINK_DIV cycles per half-phase.
  - Held at 1 in CLOCK mode.
  - Reset to 1 on entry to SETUP.
- Reset mid-operation: immediate asynchronous clear; no pending pulses survive reset.

Optional Feature:
- Macro: HMS_ALARM_EN.
- When defined, the block adds these ports:
  - i_alarm_hour (5 bits) and i_alarm_min (6 bits): alarm time.
  - i_alarm_arm (1 bit): arms the alarm.
  - i_alarm_ack_pls (1 bit): acknowledge pulse.
  - o_alarm (1 bit): alarm output.
- o_alarm behaviour:
  - Sets on the CLOCK-mode tick that makes hour/min equal the alarm time with sec = 0, provided i_alarm_arm = 1.
  - Clears on i_alarm_ack_pls, on i_alarm_arm = 0, or after 60 ticks.
  - Reset value is 0.
  - Never sets in SETUP.
- When the macro is not defined, those ports and all alarm logic are absent.

Decomposition:
- Package hms_pkg holds:
  - mode constants MODE_CLOCK / MODE_SETUP;
  - position constants POS_SEC / POS_MIN / POS_HOUR;
  - field widths SEC_W = 6, MIN_W = 6, HOUR_W = 5;
  - the constant 59.
- Sub-module mod_cnt: a parametrised modulo counter with inputs width W and MAX, i_en, i_inc, and output o_wrap.
  - The core instantiates it three times for sec, min and hour.
  - i_en carries the chained carry; i_inc carries the setup increment.

Test Plan:
- Reset, then CLK_HZ=20, TICK_HZ=1, run 20 cycles -> o_sec=1, one o_tick pulse, and o_day_pls stays 0.
- Preload 23:59:58 via SETUP increments, return to CLOCK, wait 2 ticks -> 00:00:00, with o_day_pls and o_tick high in the same cycle.
- In SETUP with pos SEC at 59, assert i_inc_pls -> sec=0 and min unchanged. Assert i_inc_pls in CLOCK -> no change.
- Enter SETUP mid-period (prescaler at 7), hold 100 cycles -> time frozen and o_tick never asserts. Exit -> first tick exactly 20 cycles later.
- Assert i_mode_pls and i_inc_pls in the same cycle while in CLOCK -> mode becomes SETUP and no increment. HOUR_MAX=11 build: hour 11 wraps to 0.
- HMS_ALARM_EN with alarm 00:01 armed:
  - Start at 00:00:59, one tick -> o_alarm=1. i_alarm_ack_pls -> o_alarm=0 next cycle.
  - Same setup without ack -> o_alarm clears after 60 ticks.
